// File: rtl/mod_mul_serial.sv
// -----------------------------------------------------------------------------
// mod_mul_serial
//   Bit-serial interleaved modular multiplier: out_data = (opA * opB) mod opM.
//   Walks the multiplier MSB first, one bit per clock. Each step doubles the
//   accumulator and conditionally adds the multiplicand. Both results are
//   brought back below M with at most one subtraction, because every
//   intermediate value stays below 2M.
//
//   Latency: WIDTH clocks from the acceptance edge to the out_valid cycle.
//   Throughput: one operation every WIDTH+2 clocks.
//
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operand strobe, taken only while in_ready=1
//   in_ready   high in IDLE
//   opA        multiplicand, must be < opM
//   opB        multiplier, must be < opM
//   opM        modulus, must be >= 1
//   out_valid  one-cycle result pulse
//   out_data   result, held until the next result is written
//
// Build option
//   MODMUL_ZERO_BYPASS_EN : if opA==0, opB==0 or opM==1 at acceptance, skip
//                           RUN and present 0 in the very next cycle.
// -----------------------------------------------------------------------------
module mod_mul_serial #(
    parameter int WIDTH = 256,
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] opM,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] accR;
    logic [WIDTH-1:0] regA;
    logic [WIDTH-1:0] regB;
    logic [WIDTH-1:0] regM;
    logic [CNT_W-1:0] cnt;

    // One iteration step. All arithmetic is WIDTH+1 bits wide so that 2R and
    // D+A, both below 2M, can never wrap.
    logic [WIDTH:0]   dblRaw;
    logic [WIDTH:0]   dblRed;
    logic [WIDTH:0]   sumRaw;
    logic [WIDTH:0]   sumRed;
    logic [WIDTH:0]   modExt;
    logic [WIDTH-1:0] nextR;

    always_comb begin
        modExt = {1'b0, regM};
        dblRaw = {accR, 1'b0};
        dblRed = (dblRaw >= modExt) ? (dblRaw - modExt) : dblRaw;
        sumRaw = dblRed + {1'b0, regA};
        sumRed = (sumRaw >= modExt) ? (sumRaw - modExt) : sumRaw;
        nextR  = regB[cnt] ? sumRed[WIDTH-1:0] : dblRed[WIDTH-1:0];
    end

`ifdef MODMUL_ZERO_BYPASS_EN
    // The product is trivially 0, so no iterations are needed.
    logic isTrivial;
    assign isTrivial = (opA == '0) || (opB == '0) || (opM == WIDTH'(1));
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_data  <= '0;
            accR      <= '0;
            regA      <= '0;
            regB      <= '0;
            regM      <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        regA     <= opA;
                        regB     <= opB;
                        regM     <= opM;
                        accR     <= '0;
                        cnt      <= CNT_W'(WIDTH - 1);
                        in_ready <= 1'b0;
`ifdef MODMUL_ZERO_BYPASS_EN
                        if (isTrivial) begin
                            out_data  <= '0;
                            out_valid <= 1'b1;
                            state     <= DONE;
                        end else begin
                            state <= RUN;
                        end
`else
                        state <= RUN;
`endif
                    end
                end

                RUN: begin
                    accR <= nextR;
                    if (cnt == '0) begin
                        // The last step goes straight to the output, with no
                        // extra cycle through accR.
                        out_data  <= nextR;
                        out_valid <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end

                DONE: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end

                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mod_mul_serial.sv
// -----------------------------------------------------------------------------
// tb_mod_mul_serial
//   Directed vectors for mod_mul_serial at WIDTH=256. The expected products
//   are worked out by hand: small residues, and secp256k1 / 2^256-1 identities
//   such as (M-1)^2 == 1. Cycle timing is measured in edges after the
//   acceptance edge.
// -----------------------------------------------------------------------------
module tb_mod_mul_serial;

    localparam int W = 256;
    localparam logic [W-1:0] P    = 256'hFFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFF_FFFFFFFE_FFFFFC2F;
    localparam logic [W-1:0] HALF = (P + 256'd1) >> 1;   // 2*HALF == 1 mod P
    localparam logic [W-1:0] MAXM = '1;                  // 2^256-1
    localparam logic [W-1:0] TOP  = {1'b1, 255'd0};      // 2^255; 2*TOP == 1 mod MAXM
`ifdef MODMUL_ZERO_BYPASS_EN
    localparam int ZLAT = 0;   // result already visible in the cycle after acceptance
`else
    localparam int ZLAT = W;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] opA = '0;
    logic [W-1:0] opB = '0;
    logic [W-1:0] opM = '0;
    logic         out_valid;
    logic [W-1:0] out_data;

    int           nTests = 0;
    int           nFail = 0;
    logic [W-1:0] lastData = '0;   // value out_data must currently be holding

    mod_mul_serial #(.WIDTH(W), .CNT_W(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .opA       (opA),
        .opB       (opB),
        .opM       (opM),
        .out_valid (out_valid),
        .out_data  (out_data)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        nTests++;
        if (got !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Count out_valid pulses over a window (used to prove none appear).
    task automatic countPulses(input int cycles, output int pulses);
        pulses = 0;
        for (int i = 0; i < cycles; i++) begin
            @(posedge clk); #1;
            if (out_valid) pulses++;
        end
    endtask

    // One full operation. expEdges = edges after acceptance before out_valid
    // is seen. A non-negative intrudeAt pulses a second request during RUN.
    task automatic runOp(input string tag, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] m, input int expEdges,
                         input logic [W-1:0] expData, input int intrudeAt);
        int n;
        bit readySeen;
        n = 0;
        while (!in_ready && n < 2 * W) begin
            @(posedge clk); #1; n++;
        end
        check({tag, " ready"}, W'(in_ready), W'(1));
        opA = a; opB = b; opM = m; in_valid = 1'b1;
        @(posedge clk); #1;                     // acceptance edge
        in_valid = 1'b0;
        opA = '1; opB = '1; opM = '1;           // operands must already be latched
        n = 0;
        readySeen = 1'b0;
        while (!out_valid && n < 2 * W) begin
            if (in_ready) readySeen = 1'b1;
            if (n == intrudeAt) begin
                opA = 256'd9; opB = 256'd9; opM = 256'd11; in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            if (n == W / 2) check({tag, " hold"}, out_data, lastData);
            @(posedge clk); #1; n++;
        end
        in_valid = 1'b0;
        check({tag, " latency"}, W'(n), W'(expEdges));
        check({tag, " busy"}, W'(readySeen), W'(0));
        check({tag, " data"}, out_data, expData);
        check({tag, " ready in DONE"}, W'(in_ready), W'(0));
        lastData = expData;
        @(posedge clk); #1;
        check({tag, " pulse end"}, W'(out_valid), W'(0));
        check({tag, " ready again"}, W'(in_ready), W'(1));
        check({tag, " held"}, out_data, lastData);
    endtask

    initial begin
        int pulses;
        repeat (3) @(posedge clk);
        #1;
        check("reset out_valid", W'(out_valid), W'(0));
        check("reset in_ready", W'(in_ready), W'(1));
        check("reset out_data", out_data, '0);
        @(negedge clk) rst_n = 1'b1;

        runOp("3*5%7",     256'd3,     256'd5, 256'd7, W, 256'd1, -1);
        runOp("(p-1)^2",   P - 1,      P - 1,  P,      W, 256'd1, -1);
        runOp("2*(p+1)/2", 256'd2,     HALF,   P,      W, 256'd1, -1);
        runOp("2^255*2",   TOP,        256'd2, MAXM,   W, 256'd1, -1);
        runOp("(M-1)^2",   MAXM - 1,   MAXM-1, MAXM,   W, 256'd1, -1);
        runOp("(p-1)*2",   P - 1,      256'd2, P,      W, P - 2,  -1);
        runOp("10*10%13",  256'd10,    256'd10,256'd13,W, 256'd9, -1);

        // Second request mid-RUN must be dropped without disturbing the job.
        runOp("intrude",   256'd3,     256'd5, 256'd7, W, 256'd1, 50);
        countPulses(W + 10, pulses);
        check("intrude no 2nd pulse", W'(pulses), W'(0));

        // Reset 100 edges into RUN.
        opA = 256'd3; opB = 256'd5; opM = 256'd7; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (100) @(posedge clk);
        #1;
        check("pre-reset busy", W'(in_ready), W'(0));
        rst_n = 1'b0;
        #1;
        check("abort out_valid", W'(out_valid), W'(0));
        check("abort out_data", out_data, '0);
        check("abort in_ready", W'(in_ready), W'(1));
        lastData = '0;
        @(negedge clk) rst_n = 1'b1;
        countPulses(W + 10, pulses);
        check("abort no pulse", W'(pulses), W'(0));
        runOp("4*6%7",     256'd4,     256'd6, 256'd7, W, 256'd3, -1);

        runOp("A=0",       256'd0,     256'd12345, P,  ZLAT, 256'd0, -1);
        runOp("(5*3)%7",   256'd5,     256'd3, 256'd7, W, 256'd1, -1);
        runOp("M=1",       256'd0,     256'd0, 256'd1, ZLAT, 256'd0, -1);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, %0d checks done", nTests);
        $fatal(1);
    end

endmodule
